// File: rtl/pc_unit_rs.sv
// Program counter with a circular hardware return-address stack.
// Supports stall, PC-relative branch, absolute jump, call (jal) with push,
// return with pop, and sticky overflow/underflow error flags.
module pc_unit_rs #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned DISP_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic [DISP_W-1:0] i_disp,
    input  logic              i_jump,
    input  logic              i_jal,
    input  logic              i_ret,
    input  logic [PC_W-1:0]   i_target,
    input  logic              i_clr_err,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_link,
    output logic              o_stack_full,
    output logic              o_stack_empty,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  link_q, link_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic             ovf_set;
    logic             unf_set;
    logic             full;
    logic             empty;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  disp_ext;
    logic [PC_W-1:0]  stack_mem [DEPTH];

    // Sign-extending cast of the displacement to PC width.
    assign disp_ext = PC_W'($signed(i_disp));
    assign pc_inc   = pc_q + PC_W'(1);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

    // Next-state selection; only the highest-priority control has any effect.
    always_comb begin
        pc_d    = pc_q;
        link_d  = link_q;
        top_d   = top_q;
        count_d = count_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (i_stall) begin
            // Hold everything except the error-clear path.
        end else if (i_branch) begin
            pc_d = pc_q + disp_ext;
        end else if (i_jal) begin
            pc_d   = i_target;
            link_d = pc_inc;
            push   = 1'b1;
            // Advancing top when full lands on the oldest entry, overwriting it.
            top_d  = top_q + PTR_W'(1);
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (i_jump) begin
            pc_d = i_target;
        end else if (i_ret) begin
            if (!empty) begin
                pc_d    = stack_mem[top_q];
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end else begin
                pc_d    = pc_inc;
                unf_set = 1'b1;
            end
        end else begin
            pc_d = pc_inc;
        end
        // Set wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~i_clr_err);
        unf_d = unf_set | (unf_q & ~i_clr_err);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pc_q    <= PC_W'(RESET_VEC);
            link_q  <= '0;
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            link_q  <= link_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push && !RESET) begin
            stack_mem[top_d] <= pc_inc;
        end
    end

    assign o_pc          = pc_q;
    assign o_link        = link_q;
    assign o_stack_full  = full;
    assign o_stack_empty = empty;
    assign o_ovf         = ovf_q;
    assign o_unf         = unf_q;

endmodule

// File: tb/tb_pc_unit_rs.sv
// Directed testbench for pc_unit_rs with default parameters.
module tb_pc_unit_rs;

    logic        clk;
    logic        RESET;
    logic        i_stall;
    logic        i_branch;
    logic [7:0]  i_disp;
    logic        i_jump;
    logic        i_jal;
    logic        i_ret;
    logic [15:0] i_target;
    logic        i_clr_err;
    logic [15:0] o_pc;
    logic [15:0] o_link;
    logic        o_stack_full;
    logic        o_stack_empty;
    logic        o_ovf;
    logic        o_unf;

    int checks = 0;
    int errors = 0;

    pc_unit_rs #(
        .PC_W(16),
        .DISP_W(8),
        .DEPTH(4),
        .RESET_VEC(0)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .i_stall(i_stall),
        .i_branch(i_branch),
        .i_disp(i_disp),
        .i_jump(i_jump),
        .i_jal(i_jal),
        .i_ret(i_ret),
        .i_target(i_target),
        .i_clr_err(i_clr_err),
        .o_pc(o_pc),
        .o_link(o_link),
        .o_stack_full(o_stack_full),
        .o_stack_empty(o_stack_empty),
        .o_ovf(o_ovf),
        .o_unf(o_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        i_stall   = 1'b0;
        i_branch  = 1'b0;
        i_disp    = 8'h00;
        i_jump    = 1'b0;
        i_jal     = 1'b0;
        i_ret     = 1'b0;
        i_target  = 16'h0000;
        i_clr_err = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [15:0] t);
        idle();
        i_jump   = 1'b1;
        i_target = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b1;
        #3;
        checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", o_pc); end
        checks++; if (o_link !== 16'h0000) begin errors++; $display("FAIL reset_link got %h want 0000", o_link); end
        checks++; if ({o_stack_empty, o_stack_full, o_ovf, o_unf} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got %b want 1000", {o_stack_empty, o_stack_full, o_ovf, o_unf});
        end
        @(posedge clk);
        #1;
        RESET = 1'b0;
        checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL run_pc0 got %h want 0000", o_pc); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (o_pc !== 16'(i)) begin errors++; $display("FAIL run_pc%0d got %h want %h", i, o_pc, 16'(i)); end
        end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL run_empty got %b want 1", o_stack_empty); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL async_reset got %h want 0000", o_pc); end
        @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_branch();
        go_to(16'h0010);
        checks++; if (o_pc !== 16'h0010) begin errors++; $display("FAIL jump_pc got %h want 0010", o_pc); end
        i_branch = 1'b1; i_disp = 8'hFE;
        step();
        checks++; if (o_pc !== 16'h000E) begin errors++; $display("FAIL branch_neg got %h want 000e", o_pc); end
        i_disp = 8'h05;
        step();
        checks++; if (o_pc !== 16'h0013) begin errors++; $display("FAIL branch_pos got %h want 0013", o_pc); end
        go_to(16'hFFFF);
        step();
        checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", o_pc); end
    endtask

    task automatic test_jal_ret();
        go_to(16'h0020);
        i_jal = 1'b1; i_target = 16'h0100;
        step();
        idle();
        checks++; if (o_pc !== 16'h0100) begin errors++; $display("FAIL jal_pc got %h want 0100", o_pc); end
        checks++; if (o_link !== 16'h0021) begin errors++; $display("FAIL jal_link got %h want 0021", o_link); end
        checks++; if (o_stack_empty !== 1'b0) begin errors++; $display("FAIL jal_empty got %b want 0", o_stack_empty); end
        i_ret = 1'b1;
        step();
        idle();
        checks++; if (o_pc !== 16'h0021) begin errors++; $display("FAIL ret_pc got %h want 0021", o_pc); end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b want 1", o_stack_empty); end
    endtask

    task automatic test_nested();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0051; exp_ret[1] = 16'h0041; exp_ret[2] = 16'h0031; exp_ret[3] = 16'h0021;
        for (int k = 1; k <= 5; k++) begin
            go_to(16'(k * 16));
            i_jal = 1'b1; i_target = 16'h0200;
            step();
            idle();
            if (k == 3) begin
                checks++; if (o_stack_full !== 1'b0) begin errors++; $display("FAIL nest3_full got %b want 0", o_stack_full); end
            end
            if (k == 4) begin
                checks++; if (o_stack_full !== 1'b1) begin errors++; $display("FAIL nest4_full got %b want 1", o_stack_full); end
                checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL nest4_ovf got %b want 0", o_ovf); end
            end
        end
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL nest5_ovf got %b want 1", o_ovf); end
        checks++; if (o_stack_full !== 1'b1) begin errors++; $display("FAIL nest5_full got %b want 1", o_stack_full); end
        checks++; if (o_link !== 16'h0051) begin errors++; $display("FAIL nest5_link got %h want 0051", o_link); end
        for (int k = 0; k < 4; k++) begin
            i_ret = 1'b1;
            step();
            checks++; if (o_pc !== exp_ret[k]) begin errors++; $display("FAIL pop%0d got %h want %h", k, o_pc, exp_ret[k]); end
        end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b want 1", o_stack_empty); end
        checks++; if (o_unf !== 1'b0) begin errors++; $display("FAIL pop_unf_early got %b want 0", o_unf); end
        step();
        idle();
        checks++; if (o_pc !== 16'h0022) begin errors++; $display("FAIL unf_pc got %h want 0022", o_pc); end
        checks++; if (o_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", o_unf); end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL unf_empty got %b want 1", o_stack_empty); end
        i_clr_err = 1'b1;
        step();
        idle();
        checks++; if ({o_ovf, o_unf} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b want 00", {o_ovf, o_unf}); end
    endtask

    task automatic test_stall();
        go_to(16'h0030);
        i_stall = 1'b1; i_jal = 1'b1; i_target = 16'h0300;
        step();
        checks++; if (o_pc !== 16'h0030) begin errors++; $display("FAIL stall_pc got %h want 0030", o_pc); end
        checks++; if (o_link !== 16'h0051) begin errors++; $display("FAIL stall_link got %h want 0051", o_link); end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL stall_empty got %b want 1", o_stack_empty); end
        i_stall = 1'b0;
        step();
        idle();
        checks++; if (o_pc !== 16'h0300) begin errors++; $display("FAIL unstall_pc got %h want 0300", o_pc); end
        checks++; if (o_link !== 16'h0031) begin errors++; $display("FAIL unstall_link got %h want 0031", o_link); end
        checks++; if (o_stack_empty !== 1'b0) begin errors++; $display("FAIL unstall_empty got %b want 0", o_stack_empty); end
    endtask

    task automatic test_priority();
        // One entry (0x0031) is on the stack from the stall test.
        i_branch = 1'b1; i_disp = 8'h04; i_jal = 1'b1; i_target = 16'h0400;
        step();
        idle();
        checks++; if (o_pc !== 16'h0304) begin errors++; $display("FAIL prio_pc got %h want 0304", o_pc); end
        checks++; if (o_link !== 16'h0031) begin errors++; $display("FAIL prio_link got %h want 0031", o_link); end
        i_ret = 1'b1;
        step();
        idle();
        checks++; if (o_pc !== 16'h0031) begin errors++; $display("FAIL prio_ret got %h want 0031", o_pc); end
        checks++; if (o_stack_empty !== 1'b1) begin errors++; $display("FAIL prio_empty got %b want 1", o_stack_empty); end
    endtask

    task automatic test_clr_same_cycle();
        for (int k = 0; k < 4; k++) begin
            i_jal = 1'b1; i_target = 16'h0040;
            step();
        end
        idle();
        checks++; if ({o_stack_full, o_ovf} !== 2'b10) begin errors++; $display("FAIL fill_flags got %b want 10", {o_stack_full, o_ovf}); end
        i_jal = 1'b1; i_target = 16'h0040; i_clr_err = 1'b1;
        step();
        idle();
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", o_ovf); end
        i_clr_err = 1'b1;
        step();
        idle();
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", o_ovf); end
        checks++; if (o_stack_full !== 1'b1) begin errors++; $display("FAIL clr_full got %b want 1", o_stack_full); end
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        test_reset();
        test_branch();
        test_jal_ret();
        test_nested();
        test_stall();
        test_priority();
        test_clr_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
